// File: rtl/wci_master_port.sv
// -----------------------------------------------------------------------------
// wci_master_port
//
// Single-channel WCI (OCP) control-plane initiator. Accepts one request at a
// time from the container control fabric, issues it to one worker's wci_s_*
// port as an OCP read or write, waits for SResp and hands back data/status.
// Every access is bounded by a cycle timeout. After a timeout the port enters
// a sticky fail mode: requests are answered with FAIL and never reach the
// worker until clr_timeout is pulsed. Worker attention (SFlag[0]) is latched
// independently of the access state machine.
//
// Ports
//   CLK, RST_N                 clock (rising edge) / synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_write, req_space       1=write/0=read, MAddrSpace (0=control, 1=config)
//   req_byteen, req_addr       byte enables, address
//   req_data, req_mflag        write data (ignored on reads), MFlag for access
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_status       SData / 0 / TIMEOUT_DATA; 0=OK 1=ERR 2=FAIL 3=TIMEOUT
//   clr_timeout, timed_out     clear pulse / sticky timeout flag
//   clr_attn, attn             clear pulse / sticky SFlag[0] attention
//   wci_m_*                    OCP master signals toward the worker
//
// All outputs come straight from flops. Output flops are loaded from the
// next-state decode so that they line up with the state they belong to.
// -----------------------------------------------------------------------------
module wci_master_port #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,  // 4..65535
  parameter logic [31:0] TIMEOUT_DATA   = 32'hC0DE4203
) (
  input  logic        CLK,
  input  logic        RST_N,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_space,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_mflag,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  // sticky status
  input  logic        clr_timeout,
  output logic        timed_out,
  output logic        attn,
  input  logic        clr_attn,
  // OCP master side
  output logic [2:0]  wci_m_MCmd,
  output logic        wci_m_MAddrSpace,
  output logic [3:0]  wci_m_MByteEn,
  output logic [31:0] wci_m_MAddr,
  output logic [31:0] wci_m_MData,
  output logic [1:0]  wci_m_MFlag,
  input  logic [1:0]  wci_m_SResp,
  input  logic [31:0] wci_m_SData,
  input  logic        wci_m_SThreadBusy,
  input  logic [1:0]  wci_m_SFlag
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PEND = 3'd1,
    S_CMD  = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_e;

  localparam logic [2:0]  MCMD_IDLE = 3'd0;
  localparam logic [2:0]  MCMD_WR   = 3'd1;
  localparam logic [2:0]  MCMD_RD   = 3'd2;

  localparam logic [1:0]  SRESP_NULL = 2'd0;
  localparam logic [1:0]  SRESP_DVA  = 2'd1;
  localparam logic [1:0]  SRESP_FAIL = 2'd2;
  localparam logic [1:0]  SRESP_ERR  = 2'd3;

  localparam logic [1:0]  ST_OK      = 2'd0;
  localparam logic [1:0]  ST_ERR     = 2'd1;
  localparam logic [1:0]  ST_FAIL    = 2'd2;
  localparam logic [1:0]  ST_TIMEOUT = 2'd3;

  // Last counter value at which a response is still accepted.
  localparam logic [15:0] CNT_LAST = TIMEOUT_CYCLES - 16'd1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  // captured request
  logic        wr_q, wr_d;
  logic        space_q, space_d;
  logic [3:0]  byteen_q, byteen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  mflag_q, mflag_d;

  // response and sticky flags
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic        timed_out_q, timed_out_d;
  logic        attn_q, attn_d;

  // registered outputs
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [2:0]  mcmd_q, mcmd_d;
  logic        maddrspace_q, maddrspace_d;
  logic [3:0]  mbyteen_q, mbyteen_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mdata_q, mdata_d;
  logic [1:0]  mflag_out_q, mflag_out_d;

  logic        expired;
  logic        timeout_hit;

  // SFlag[1] carries no meaning for this port.
  logic        unused_sflag;
  assign unused_sflag = wci_m_SFlag[1];

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    space_d      = space_q;
    byteen_d     = byteen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mflag_d      = mflag_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    timeout_hit  = 1'b0;
    expired      = (cnt_q == CNT_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d     = req_write;
          space_d  = req_space;
          byteen_d = req_byteen;
          addr_d   = req_addr;
          wdata_d  = req_data;
          mflag_d  = req_mflag;
          cnt_d    = 16'd0;
          if (timed_out_q) begin
            // Sticky fail mode: answer locally, the worker never sees it.
            state_d      = S_RESP;
            rsp_status_d = ST_FAIL;
            rsp_data_d   = TIMEOUT_DATA;
          end else begin
            state_d = S_PEND;
          end
        end
      end

      S_PEND: begin
        cnt_d = cnt_q + 16'd1;
        if (expired)                 timeout_hit = 1'b1;
        else if (!wci_m_SThreadBusy) state_d     = S_CMD;
      end

      S_CMD: begin
        cnt_d = cnt_q + 16'd1;
        if (expired) timeout_hit = 1'b1;
        else         state_d     = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A response arriving on the expiry cycle still counts as on time.
        if (wci_m_SResp != SRESP_NULL) begin
          state_d    = S_RESP;
          rsp_data_d = wr_q ? 32'd0 : wci_m_SData;
          unique case (wci_m_SResp)
            SRESP_DVA:  rsp_status_d = ST_OK;
            SRESP_FAIL: rsp_status_d = ST_FAIL;
            SRESP_ERR:  rsp_status_d = ST_ERR;
            default:    rsp_status_d = ST_OK;
          endcase
        end else if (expired) begin
          timeout_hit = 1'b1;
        end
      end

      S_RESP: begin
        // rsp_valid is high throughout RESP, so rsp_ready alone completes it.
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      state_d      = S_RESP;
      rsp_status_d = ST_TIMEOUT;
      rsp_data_d   = TIMEOUT_DATA;
    end

    // Setting beats clearing for both sticky flags.
    timed_out_d = timeout_hit | (timed_out_q & ~clr_timeout);
    attn_d      = wci_m_SFlag[0] | (attn_q & ~clr_attn);

    // Output flops follow the state being entered.
    req_ready_d  = (state_d == S_IDLE);
    rsp_valid_d  = (state_d == S_RESP);
    mcmd_d       = MCMD_IDLE;
    maddrspace_d = 1'b0;
    mbyteen_d    = 4'd0;
    maddr_d      = 32'd0;
    mdata_d      = 32'd0;
    if (state_d == S_CMD) begin
      mcmd_d       = wr_d ? MCMD_WR : MCMD_RD;
      maddrspace_d = space_d;
      mbyteen_d    = byteen_d;
      maddr_d      = addr_d;
      mdata_d      = wr_d ? wdata_d : 32'd0;
    end
    mflag_out_d = (state_d == S_PEND || state_d == S_CMD || state_d == S_WAIT)
                  ? mflag_d : 2'd0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      wr_q         <= 1'b0;
      space_q      <= 1'b0;
      byteen_q     <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      mflag_q      <= 2'd0;
      rsp_data_q   <= 32'd0;
      rsp_status_q <= 2'd0;
      timed_out_q  <= 1'b0;
      attn_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      mcmd_q       <= MCMD_IDLE;
      maddrspace_q <= 1'b0;
      mbyteen_q    <= 4'd0;
      maddr_q      <= 32'd0;
      mdata_q      <= 32'd0;
      mflag_out_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      space_q      <= space_d;
      byteen_q     <= byteen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mflag_q      <= mflag_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      timed_out_q  <= timed_out_d;
      attn_q       <= attn_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      mcmd_q       <= mcmd_d;
      maddrspace_q <= maddrspace_d;
      mbyteen_q    <= mbyteen_d;
      maddr_q      <= maddr_d;
      mdata_q      <= mdata_d;
      mflag_out_q  <= mflag_out_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_status       = rsp_status_q;
  assign timed_out        = timed_out_q;
  assign attn             = attn_q;
  assign wci_m_MCmd       = mcmd_q;
  assign wci_m_MAddrSpace = maddrspace_q;
  assign wci_m_MByteEn    = mbyteen_q;
  assign wci_m_MAddr      = maddr_q;
  assign wci_m_MData      = mdata_q;
  assign wci_m_MFlag      = mflag_out_q;

endmodule
